// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default link constants
// and a ceiling-log2 helper for sizing counters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int CLKS_PER_BIT_9600 = 5208;
    localparam int UART_DATA_BITS    = 8;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// is a parameter so idle-high and idle-low lines can share it.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with self-timed mid-bit sampling from the system
// clock; delivers bytes with a one-cycle valid strobe or a framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int IDX_W = clog2(DATA_BITS + 1);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clock (clock),
        .rst   (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // LSB arrives first, so each new bit enters at the top and slides down.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q + IDX_W'(1);
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                BREAK: begin
                    // Hold off until the line recovers so a break cannot retrigger.
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: a frame table plus
// hand-written glitch, break, back-to-back and mid-frame reset sequences.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int LAT_MIN = 154;
    localparam int LAT_MAX = 155;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge away from DUT updates.
    int         n_valid   = 0;
    int         n_ferr    = 0;
    int         n_busy    = 0;
    int         n_overlap = 0;
    int         n_wide    = 0;
    int         ev_cyc    = 0;
    logic [7:0] ev_data   = 8'h00;
    logic       prev_pulse = 1'b0;

    always @(negedge clock) begin
        if (rx_valid) begin
            n_valid = n_valid + 1;
            ev_cyc  = cyc;
            ev_data = rx_data;
        end
        if (frame_err) begin
            n_ferr = n_ferr + 1;
            ev_cyc = cyc;
        end
        if (rx_valid && frame_err) n_overlap = n_overlap + 1;
        if ((rx_valid || frame_err) && prev_pulse) n_wide = n_wide + 1;
        prev_pulse = rx_valid || frame_err;
        if (busy) n_busy = n_busy + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total = n_total + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_total = n_total + 1;
        if (act >= lo && act <= hi) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    int fall_cyc = 0;

    // Drives start, data (LSB first) and stop bits; leaves rx at the stop level.
    // Edge k (k=1..9) is displaced by +jit for odd k and -jit for even k.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int jit);
        logic [9:0] bits;
        int         s [0:10];
        bits = {stop_v, d, 1'b0};
        for (int k = 0; k <= 10; k++)
            s[k] = (k == 0 || k == 10) ? 0 : ((k % 2 == 1) ? jit : -jit);
        fall_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            ticks(CPB + s[k+1] - s[k]);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         jit;
        int         hold;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int v0, f0, b0, t1, t2;
        logic [7:0] d1, d2;

        vecs[0] = '{8'hA5, 1'b1,  0,  0, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1,  0,  0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1,  0,  0, 1, 0, 8'hFF};
        vecs[3] = '{8'h5A, 1'b1,  3,  0, 1, 0, 8'h5A};
        vecs[4] = '{8'h5A, 1'b1, -3,  0, 1, 0, 8'h5A};
        vecs[5] = '{8'h3C, 1'b0,  0, 40, 0, 1, 8'h5A};
        vecs[6] = '{8'h3C, 1'b1,  0,  0, 1, 0, 8'h3C};
        vecs[7] = '{8'hC3, 1'b1,  2,  0, 1, 0, 8'hC3};

        rst = 1'b1;
        rx  = 1'b1;
        ticks(3);
        chk("rst_data",  int'(rx_data),   0);
        chk("rst_valid", int'(rx_valid),  0);
        chk("rst_ferr",  int'(frame_err), 0);
        chk("rst_busy",  int'(busy),      0);
        rst = 1'b0;
        ticks(5);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].jit);
            ticks(vecs[i].hold);
            rx = 1'b1;
            ticks(20);
            chk($sformatf("vec%0d_valid_cnt", i), n_valid - v0, vecs[i].exp_valid);
            chk($sformatf("vec%0d_ferr_cnt", i),  n_ferr - f0,  vecs[i].exp_ferr);
            chk($sformatf("vec%0d_rx_data", i),   int'(rx_data), int'(vecs[i].exp_data));
            chk_range($sformatf("vec%0d_latency", i), ev_cyc - fall_cyc, LAT_MIN, LAT_MAX);
            chk($sformatf("vec%0d_busy_after", i), int'(busy), 0);
        end

        // Back-to-back 0x00 then 0xFF with no idle gap.
        v0 = n_valid;
        send_frame(8'h00, 1'b1, 0);
        t1 = ev_cyc;
        d1 = ev_data;
        send_frame(8'hFF, 1'b1, 0);
        rx = 1'b1;
        ticks(20);
        t2 = ev_cyc;
        d2 = ev_data;
        chk("b2b_count",   n_valid - v0, 2);
        chk("b2b_first",   int'(d1), 8'h00);
        chk("b2b_second",  int'(d2), 8'hFF);
        chk("b2b_spacing", t2 - t1, 160);

        // Five-cycle glitch on the idle line.
        v0 = n_valid;
        f0 = n_ferr;
        b0 = n_busy;
        rx = 1'b0;
        ticks(5);
        rx = 1'b1;
        ticks(30);
        chk_range("glitch_busy_cycles", n_busy - b0, 1, 8);
        chk("glitch_busy_now", int'(busy), 0);
        chk("glitch_strobes",  (n_valid - v0) + (n_ferr - f0), 0);

        // Bad stop bit followed by a held-low line.
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 0);
        ticks(20);
        chk("break_busy_held", int'(busy), 1);
        chk("break_ferr_cnt",  n_ferr - f0, 1);
        chk("break_valid_cnt", n_valid - v0, 0);
        chk("break_data_kept", int'(rx_data), 8'hFF);
        ticks(20);
        rx = 1'b1;
        ticks(6);
        chk("break_released", int'(busy), 0);
        chk("break_no_frame", (n_valid - v0) + (n_ferr - f0), 1);
        v0 = n_valid;
        send_frame(8'h3C, 1'b1, 0);
        rx = 1'b1;
        ticks(20);
        chk("after_break_valid", n_valid - v0, 1);
        chk("after_break_data",  int'(rx_data), 8'h3C);

        // Reset during bit 4 of 0xF0; the rest of that frame is all ones.
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        ticks(CPB * 5);
        rx = 1'b1;
        ticks(CPB / 2);
        chk("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        ticks(1);
        chk("midrst_data",  int'(rx_data),   0);
        chk("midrst_valid", int'(rx_valid),  0);
        chk("midrst_ferr",  int'(frame_err), 0);
        chk("midrst_busy",  int'(busy),      0);
        rst = 1'b0;
        ticks(CPB / 2 + CPB * 4 + 20);
        chk("midrst_no_strobe", (n_valid - v0) + (n_ferr - f0), 0);
        chk("midrst_idle", int'(busy), 0);
        v0 = n_valid;
        send_frame(8'h81, 1'b1, 0);
        rx = 1'b1;
        ticks(20);
        chk("post_rst_valid", n_valid - v0, 1);
        chk("post_rst_data",  int'(rx_data), 8'h81);
        chk_range("post_rst_latency", ev_cyc - fall_cyc, LAT_MIN, LAT_MAX);

        chk("pulse_overlap", n_overlap, 0);
        chk("pulse_width",   n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
